iob_vexriscv_bus_bridge: RTL
============================

IOB_VEXRISCV_BUS_BRIDGE -- requirements
Module: iob_vexriscv_bus_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width, multiple of 8.
REQ-003 SHALL have parameter CMD_DEPTH, default 4, command FIFO entries, power of two, at least 2.
REQ-004 SHALL have parameter TIMEOUT_W, default 8, timeout counter width.
REQ-005 SHALL use one clock; reset is asynchronous and active-low: clk input 1, system clock; rst_n input 1, async active-low reset.
REQ-006 SHALL have the core command ports:
- cmd_valid input 1
- cmd_ready output 1
- cmd_wr input 1
- cmd_addr input ADDR_W
- cmd_data input DATA_W
- cmd_mask input DATA_W/8
REQ-007 SHALL have the core response ports: rsp_valid output 1; rsp_data output DATA_W; rsp_error output 1, read failed.
REQ-008 SHALL have the memory ports:
- m_valid output 1
- m_addr output ADDR_W
- m_wdata output DATA_W
- m_wstrb output DATA_W/8
- m_ready input 1, transaction complete
- m_rdata input DATA_W, valid with m_ready
REQ-009 SHALL have the status ports: busy output 1, FIFO non-empty or transaction open; timeout_flag output 1, sticky.

Function
REQ-010 SHALL accept a command when cmd_valid and cmd_ready are both high, pushing {wr, addr, data, mask} into the FIFO.
REQ-011 SHALL drive cmd_ready = FIFO not full; when full, a simultaneous pop SHALL NOT be bypassed into the push.
REQ-012 SHALL use FSM states IDLE and ISSUE:
- IDLE to ISSUE when the FIFO is non-empty, popping the head into the issue registers.
- ISSUE to IDLE on m_ready or timeout.
REQ-013 SHALL drive m_valid high only in ISSUE, with m_addr, m_wdata and m_wstrb constant until exit; m_wstrb = mask on write, 0 on read.
REQ-014 SHALL give minimum latency cmd accept (cycle T) -> m_valid at T+1 -> m_ready at T+1 -> rsp_valid at T+2; back-to-back commands SHALL issue with one IDLE cycle between them.
REQ-015 SHALL, for a read completion, register rsp_valid=1, rsp_data=m_rdata, rsp_error=0 for exactly one cycle.
REQ-016 SHALL produce no rsp_valid for a write completion.
REQ-017 SHALL ignore m_ready while in IDLE.
REQ-018 SHALL hold rsp_data at its last value when rsp_valid is low.
REQ-019 SHALL keep commands in strict FIFO order, with one memory transaction in flight.

Reset
REQ-020 SHALL, on rst_n low, asynchronously set:
- FSM to IDLE and FIFO empty
- cmd_ready=1; m_valid=0; m_addr, m_wdata, m_wstrb=0
- rsp_valid=0; rsp_data=0; rsp_error=0
- busy=0; timeout_flag=0; counter=0
REQ-021 SHALL discard any FIFO contents and any open transaction when reset is asserted mid-operation, with no response emitted.

Configuration
REQ-022 SHALL, with macro IOB_BUS_BRIDGE_TIMEOUT_EN defined:
- Count cycles in ISSUE.
- At count 2^TIMEOUT_W-1 without m_ready: exit to IDLE, set timeout_flag, and for reads emit rsp_valid=1, rsp_error=1, rsp_data=0.
- If m_ready arrives on the terminal-count cycle, treat it as normal completion.
REQ-023 SHALL, without IOB_BUS_BRIDGE_TIMEOUT_EN, have no counter, keep timeout_flag at 0, and wait in ISSUE indefinitely.

Structure
REQ-024 SHALL place the FSM state encodings and the FIFO entry-width constant (1+ADDR_W+DATA_W+DATA_W/8) in shared package iob_bus_bridge_pkg.
REQ-025 SHALL implement the FIFO as sub-module iob_bus_bridge_fifo (push/pop/full/empty, pointer wrap modulo CMD_DEPTH).

Verification
REQ-026 Single read: read addr 0x100, m_ready one cycle after m_valid with m_rdata 0xDEADBEEF -> one rsp_valid pulse, data 0xDEADBEEF, error 0.
REQ-027 Write: write addr 0x104, data 0x12345678, mask 0x3 -> m_wstrb 0x3 while m_valid, no rsp_valid.
REQ-028 Full FIFO: hold m_ready low, issue 5 commands with CMD_DEPTH 4 -> 1 in ISSUE plus 4 queued, then cmd_ready=0; release m_ready -> all complete in order.
REQ-029 Timeout (macro on, TIMEOUT_W 4): read with m_ready never asserted -> exit after 15 ISSUE cycles, rsp_error=1, timeout_flag=1; next queued command then issues.
REQ-030 Reset mid-transaction: rst_n low while in ISSUE with 2 queued -> all outputs reach reset values, no rsp_valid after release.
REQ-031 Wrap: 10 alternating read/write commands with random m_ready delay 0-3 -> pointer wrap is correct and responses match reads in order.

Source files
------------

// File: rtl/iob_bus_bridge_pkg.sv
// Shared definitions for the VexRiscv-to-memory bus bridge: FSM state
// encodings, default widths and the command FIFO entry width.
package iob_bus_bridge_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // One queued command is {wr, addr, data, mask}.
    function automatic int entry_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

endpackage

// File: rtl/iob_vexriscv_bus_bridge_if.sv
// Core command/response and memory-side signals of the bus bridge.
// slave = bridge view, master = core/memory environment view.
interface iob_vexriscv_bus_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_data;
    logic [DATA_W/8-1:0]   cmd_mask;

    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_data;
    logic                  rsp_error;

    logic                  m_valid;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_wstrb;
    logic                  m_ready;
    logic [DATA_W-1:0]     m_rdata;

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_data, cmd_mask, m_ready, m_rdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_error,
        output m_valid, m_addr, m_wdata, m_wstrb
    );

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_data, cmd_mask, m_ready, m_rdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error,
        input  m_valid, m_addr, m_wdata, m_wstrb
    );
endinterface

// File: rtl/iob_bus_bridge_fifo.sv
// Command FIFO for the bus bridge. Pointers carry one extra wrap bit so
// full and empty are distinguishable; push is refused while full, pop
// is refused while empty. Storage is not reset, only the pointers.
module iob_bus_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    // Pointer advance; the index bits wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end
endmodule

// File: rtl/iob_vexriscv_bus_bridge.sv
// VexRiscv core to simple memory bus bridge. Commands are queued in a
// FIFO and issued one at a time; read completions produce a one-cycle
// response. An incoming command that finds the bridge idle with an empty
// FIFO goes straight to the bus, giving a one-cycle accept-to-issue path.
// Optional feature macro: IOB_BUS_BRIDGE_TIMEOUT_EN (ISSUE timeout).
module iob_vexriscv_bus_bridge
    import iob_bus_bridge_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    iob_vexriscv_bus_bridge_if.slave bus,
    output logic                     busy,
    output logic                     timeout_flag
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int ENTRY_W = entry_w(ADDR_W, DATA_W);

    state_t              state;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                accept;
    logic                bypass;
    logic                start;
    logic [ENTRY_W-1:0]  cmd_entry;
    logic [ENTRY_W-1:0]  fifo_head;
    logic [ENTRY_W-1:0]  next_entry;
    logic                nxt_wr;
    logic [ADDR_W-1:0]   nxt_addr;
    logic [DATA_W-1:0]   nxt_data;
    logic [STRB_W-1:0]   nxt_mask;

    // issue stage
    logic                wr_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic [DATA_W-1:0]   wdata_p1;
    logic [STRB_W-1:0]   wstrb_p1;

    // response stage
    logic                rsp_vld_p2;
    logic                rsp_err_p2;
    logic [DATA_W-1:0]   rsp_data_p2;

`ifdef IOB_BUS_BRIDGE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt;
`endif

    assign accept     = bus.cmd_valid && !fifo_full;
    assign bypass     = accept && (state == IDLE) && fifo_empty;
    assign fifo_push  = accept && !bypass;
    assign fifo_pop   = (state == IDLE) && !fifo_empty;
    assign start      = fifo_pop || bypass;

    assign cmd_entry  = {bus.cmd_wr, bus.cmd_addr, bus.cmd_data, bus.cmd_mask};
    assign next_entry = fifo_empty ? cmd_entry : fifo_head;
    assign nxt_wr     = next_entry[ENTRY_W-1];
    assign nxt_addr   = next_entry[ENTRY_W-2 -: ADDR_W];
    assign nxt_data   = next_entry[STRB_W +: DATA_W];
    assign nxt_mask   = next_entry[STRB_W-1:0];

    iob_bus_bridge_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (cmd_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Issue FSM: load the next command onto the bus, hold it until the
    // memory completes (or the timeout expires), register the read reply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_p1       <= 1'b0;
            addr_p1     <= '0;
            wdata_p1    <= '0;
            wstrb_p1    <= '0;
            rsp_vld_p2  <= 1'b0;
            rsp_err_p2  <= 1'b0;
            rsp_data_p2 <= '0;
`ifdef IOB_BUS_BRIDGE_TIMEOUT_EN
            to_cnt       <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            rsp_vld_p2 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ISSUE;
                        wr_p1    <= nxt_wr;
                        addr_p1  <= nxt_addr;
                        wdata_p1 <= nxt_data;
                        wstrb_p1 <= nxt_wr ? nxt_mask : '0;
`ifdef IOB_BUS_BRIDGE_TIMEOUT_EN
                        to_cnt   <= TIMEOUT_W'(1);
`endif
                    end
                end
                ISSUE: begin
                    // m_ready wins over the timeout on the terminal-count cycle.
                    if (bus.m_ready) begin
                        state <= IDLE;
                        if (!wr_p1) begin
                            rsp_vld_p2  <= 1'b1;
                            rsp_err_p2  <= 1'b0;
                            rsp_data_p2 <= bus.m_rdata;
                        end
`ifdef IOB_BUS_BRIDGE_TIMEOUT_EN
                        to_cnt <= '0;
                    end else if (&to_cnt) begin
                        state        <= IDLE;
                        to_cnt       <= '0;
                        timeout_flag <= 1'b1;
                        if (!wr_p1) begin
                            rsp_vld_p2  <= 1'b1;
                            rsp_err_p2  <= 1'b1;
                            rsp_data_p2 <= '0;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef IOB_BUS_BRIDGE_TIMEOUT_EN
    assign timeout_flag = 1'b0;
`endif

    assign bus.cmd_ready = !fifo_full;
    assign bus.m_valid   = (state == ISSUE);
    assign bus.m_addr    = addr_p1;
    assign bus.m_wdata   = wdata_p1;
    assign bus.m_wstrb   = wstrb_p1;
    assign bus.rsp_valid = rsp_vld_p2;
    assign bus.rsp_error = rsp_err_p2;
    assign bus.rsp_data  = rsp_data_p2;
    assign busy          = !fifo_empty || (state == ISSUE);
endmodule
